// File: rtl/c3po_reg_arbiter_pkg.sv
// c3po_pkg: shared types and constants for the C-3PO register-bus arbiter.
// Build option: define C3PO_ARB_STATS_EN to add timeout/grant statistics counters.
package c3po_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  localparam int   C3PO_BUS_DATA_W = 32;
  localparam logic C3PO_RD         = 1'b1;
  localparam logic C3PO_WR         = 1'b0;
  localparam int   C3PO_STAT_W     = 16;

endpackage

// File: rtl/c3po_reg_arbiter_if.sv
// c3po_reg_arbiter_if: register-bus bundle between the arbiter (master) and
// the c3po_regs bank (slave).
interface c3po_reg_arbiter_if #(
  parameter int ADDR_SIZE_P = 6
);
  import c3po_pkg::*;

  logic [ADDR_SIZE_P-1:0]     bus_addr;
  logic                       bus_rd_wr;
  logic                       bus_req;
  logic [C3PO_BUS_DATA_W-1:0] bus_write_val;
  logic [C3PO_BUS_DATA_W-1:0] bus_read_val;
  logic                       bus_ack;

  modport master (
    output bus_addr, bus_rd_wr, bus_req, bus_write_val,
    input  bus_read_val, bus_ack
  );

  modport slave (
    input  bus_addr, bus_rd_wr, bus_req, bus_write_val,
    output bus_read_val, bus_ack
  );

endinterface

// File: rtl/c3po_rr_pick.sv
// c3po_rr_pick: combinational round-robin picker. Returns the first set
// request bit at or after the pointer, wrapping around the request vector.
module c3po_rr_pick #(
  parameter int NUM_REQ_P = 2,
  parameter int IDX_W     = $clog2(NUM_REQ_P)
) (
  input  logic [NUM_REQ_P-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [IDX_W-1:0]     winner_o,
  output logic                 valid_o
);

  // Scan from the pointer position and stop at the first active request
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % NUM_REQ_P]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ_P);
      end
    end
  end

endmodule

// File: rtl/c3po_reg_arbiter.sv
// c3po_reg_arbiter: shares the C-3PO register bus between NUM_REQ_P requesters
// with round-robin grant, one transaction in flight and a bus-ack timeout.
// Build option: C3PO_ARB_STATS_EN adds stat_timeouts / stat_grants outputs.
module c3po_reg_arbiter
  import c3po_pkg::*;
#(
  parameter int NUM_REQ_P   = 2,
  parameter int ADDR_SIZE_P = 6,
  parameter int TIMEOUT_P   = 8
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_REQ_P-1:0]                             rq_req,
  input  logic [NUM_REQ_P-1:0][ADDR_SIZE_P-1:0]            rq_addr,
  input  logic [NUM_REQ_P-1:0]                             rq_rd_wr,
  input  logic [NUM_REQ_P-1:0][C3PO_BUS_DATA_W-1:0]        rq_write_val,
  output logic [NUM_REQ_P-1:0]                             rq_ack,
  output logic [C3PO_BUS_DATA_W-1:0]                       rq_read_val,
  output logic                                             rq_err,
  c3po_reg_arbiter_if.master                               bus,
  output logic                                             busy
`ifdef C3PO_ARB_STATS_EN
  ,
  output logic [C3PO_STAT_W-1:0]                           stat_timeouts,
  output logic [NUM_REQ_P-1:0][C3PO_STAT_W-1:0]            stat_grants
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ_P);
  localparam int CNT_W = $clog2(TIMEOUT_P + 1);

  arb_state_t                 state_q;
  logic [IDX_W-1:0]           rrPtr_q;
  logic [IDX_W-1:0]           rrPtr_d;
  logic [IDX_W-1:0]           winner_q;
  logic [ADDR_SIZE_P-1:0]     addr_q;
  logic                       rdWr_q;
  logic [C3PO_BUS_DATA_W-1:0] wrData_q;
  logic [CNT_W-1:0]           timeoutCnt_q;
  logic                       busReq_q;
  logic [NUM_REQ_P-1:0]       rqAck_q;
  logic [C3PO_BUS_DATA_W-1:0] rqReadVal_q;
  logic                       rqErr_q;
  logic                       busy_q;

  logic [IDX_W-1:0]           pickIdx;
  logic                       pickValid;
  logic                       timeoutHit;

  c3po_rr_pick #(
    .NUM_REQ_P (NUM_REQ_P),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i    (rq_req),
    .ptr_i    (rrPtr_q),
    .winner_o (pickIdx),
    .valid_o  (pickValid)
  );

  // The requester after the current winner gets first chance next time
  assign rrPtr_d = (winner_q == IDX_W'(NUM_REQ_P - 1)) ? '0 : winner_q + IDX_W'(1);

  assign timeoutHit = (state_q == WAIT) && !bus.bus_ack &&
                      (timeoutCnt_q == CNT_W'(TIMEOUT_P));

  // Transaction FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      winner_q     <= '0;
      addr_q       <= '0;
      rdWr_q       <= 1'b0;
      wrData_q     <= '0;
      timeoutCnt_q <= '0;
      busReq_q     <= 1'b0;
      rqAck_q      <= '0;
      rqReadVal_q  <= '0;
      rqErr_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      busReq_q <= 1'b0;
      rqAck_q  <= '0;
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            winner_q <= pickIdx;
            addr_q   <= rq_addr[pickIdx];
            rdWr_q   <= rq_rd_wr[pickIdx];
            wrData_q <= rq_write_val[pickIdx];
            busReq_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (bus.bus_ack) begin
            state_q           <= RESP;
            rqAck_q[winner_q] <= 1'b1;
            rqErr_q           <= 1'b0;
            rqReadVal_q       <= (rdWr_q == C3PO_RD) ? bus.bus_read_val : '0;
          end else if (state_q == ISSUE) begin
            state_q      <= WAIT;
            timeoutCnt_q <= CNT_W'(1);
          end else if (timeoutHit) begin
            state_q           <= RESP;
            rqAck_q[winner_q] <= 1'b1;
            rqErr_q           <= 1'b1;
            rqReadVal_q       <= '0;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          rrPtr_q      <= rrPtr_d;
          rqReadVal_q  <= '0;
          rqErr_q      <= 1'b0;
          timeoutCnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_addr      = addr_q;
  assign bus.bus_rd_wr     = rdWr_q;
  assign bus.bus_req       = busReq_q;
  assign bus.bus_write_val = wrData_q;
  assign rq_ack            = rqAck_q;
  assign rq_read_val       = rqReadVal_q;
  assign rq_err            = rqErr_q;
  assign busy              = busy_q;

`ifdef C3PO_ARB_STATS_EN
  logic [C3PO_STAT_W-1:0]                statTimeouts_q;
  logic [NUM_REQ_P-1:0][C3PO_STAT_W-1:0] statGrants_q;

  // Saturating counters of timeout completions and per-requester grants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      statTimeouts_q <= '0;
      statGrants_q   <= '0;
    end else begin
      if (timeoutHit && (statTimeouts_q != '1)) begin
        statTimeouts_q <= statTimeouts_q + C3PO_STAT_W'(1);
      end
      if ((state_q == IDLE) && pickValid && (statGrants_q[pickIdx] != '1)) begin
        statGrants_q[pickIdx] <= statGrants_q[pickIdx] + C3PO_STAT_W'(1);
      end
    end
  end

  assign stat_timeouts = statTimeouts_q;
  assign stat_grants   = statGrants_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
